// File: rtl/hc595_pkg.sv
// Shared types and helpers for the 74HC595 chain driver.
// Optional build macro: HC595_READBACK_EN (adds Q7S loopback capture).
package hc595_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SH_HI = 2'd2,
      LATCH = 2'd3
   } state_e;

   localparam int BITS_PER_CHIP = 8;

   // Width of the bit counter that indexes a DW-bit word.
   function automatic int bit_cnt_w(input int dw);
      return (dw > 1) ? $clog2(dw) : 1;
   endfunction

endpackage

// File: rtl/hc595_phase_tick.sv
// Phase timer: counts CLK_DIV cycles per serial phase and flags the last one.
module hc595_phase_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic active_i,
   input  logic restart_i,
   output logic phase_end_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // With CLK_DIV=1 the counter sits at 0 and every active cycle ends a phase.
   assign phase_end_o = active_i && (cnt_q == LAST);

   // Next count: clear on phase entry or when idle, otherwise advance.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i || !active_i)
         cnt_d = '0;
      else if (!phase_end_o)
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/hc595_driver.sv
// Serial transmitter for a daisy chain of N_CHIPS 74HC595 shift registers.
// One word per valid/ready handshake, MSB first, then a storage-clock pulse.
// Optional build macro: HC595_READBACK_EN (captures the chain's Q7S output).
module hc595_driver
   import hc595_pkg::*;
#(
   parameter int N_CHIPS = 1,
   parameter int CLK_DIV = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [N_CHIPS*BITS_PER_CHIP-1:0]   data_in,
   input  logic                               valid,
   output logic                               ready,
   output logic                               done,
   input  logic                               oe_en,
`ifdef HC595_READBACK_EN
   input  logic                               hc_q7s,
   output logic [N_CHIPS*BITS_PER_CHIP-1:0]   rdata,
   output logic                               rdata_valid,
`endif
   output logic                               hc_ds,
   output logic                               hc_sh_cp,
   output logic                               hc_st_cp,
   output logic                               hc_mr_n,
   output logic                               hc_oe_n
);

   localparam int DW  = N_CHIPS * BITS_PER_CHIP;
   localparam int BCW = bit_cnt_w(DW);

   state_e          state_q, state_d;
   logic [DW-1:0]   shreg_q, shreg_d;
   logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;
   logic            ds_q, ds_d;
   logic            sh_q, sh_d;
   logic            st_q, st_d;
   logic            mr_n_q;
   logic            oe_n_q;
   logic            phase_end;

   hc595_phase_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk        (clk),
      .rst        (rst),
      .active_i   (state_q != IDLE),
      .restart_i  (state_d != state_q),
      .phase_end_o(phase_end)
   );

   // Next-state logic; pin values are derived from the next state so the
   // registered pins line up with the state they belong to.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid && ready_q) begin
               state_d   = SETUP;
               shreg_d   = data_in;
               bit_cnt_d = BCW'(DW - 1);
            end
         end
         SETUP: begin
            if (phase_end) state_d = SH_HI;
         end
         SH_HI: begin
            if (phase_end) begin
               if (bit_cnt_q == '0) begin
                  state_d = LATCH;
               end else begin
                  state_d   = SETUP;
                  shreg_d   = shreg_q << 1;
                  bit_cnt_d = bit_cnt_q - 1'b1;
               end
            end
         end
         LATCH: begin
            if (phase_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
      ds_d    = 1'b0;
      if (state_d == SETUP || state_d == SH_HI) ds_d = shreg_d[DW-1];
      sh_d    = (state_d == SH_HI);
      st_d    = (state_d == LATCH);
   end

   // State, datapath and pin registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         ds_q      <= 1'b0;
         sh_q      <= 1'b0;
         st_q      <= 1'b0;
         mr_n_q    <= 1'b0;
         oe_n_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         ds_q      <= ds_d;
         sh_q      <= sh_d;
         st_q      <= st_d;
         mr_n_q    <= 1'b1;
         oe_n_q    <= ~oe_en;
      end
   end

   assign ready    = ready_q;
   assign done     = done_q;
   assign hc_ds    = ds_q;
   assign hc_sh_cp = sh_q;
   assign hc_st_cp = st_q;
   assign hc_mr_n  = mr_n_q;
   assign hc_oe_n  = oe_n_q;

`ifdef HC595_READBACK_EN
   logic [DW-1:0] cap_q, cap_d;
   logic [DW-1:0] rdata_q;
   logic          rdv_q;

   // Q7S moves on each SH_CP rise, so it is taken in the cycle just before
   // the rise; the DW samples then reproduce the chain's prior contents.
   always_comb begin
      cap_d = cap_q;
      if (state_q == SETUP && phase_end) cap_d = {cap_q[DW-2:0], hc_q7s};
   end

   // Capture shift register and the readback word published with done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_q   <= '0;
         rdata_q <= '0;
         rdv_q   <= 1'b0;
      end else begin
         cap_q <= cap_d;
         rdv_q <= done_d;
         if (done_d) rdata_q <= cap_q;
      end
   end

   assign rdata       = rdata_q;
   assign rdata_valid = rdv_q;
`endif

endmodule

// File: tb/tb_hc595_driver.sv
// Directed bench: two drivers (1 chip / CLK_DIV=2 and 2 chips / CLK_DIV=1)
// each feeding a behavioural 74HC595 chain model.
module tb_hc595_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        oe_en;
   logic [7:0]  data0;
   logic        valid0;
   logic        ready0, done0, ds0, sh0, st0, mr0, oe0;
   logic [15:0] data1;
   logic        valid1;
   logic        ready1, done1, ds1, sh1, st1, mr1, oe1;

   int checks = 0;
   int errors = 0;

   // chip models
   logic [7:0]  sr0, q0, dslog0;
   logic [15:0] sr1, q1;
   int rise0 = 0, stc0 = 0, rise_at_st0 = 0;
   int rise1 = 0, stc1 = 0;

`ifdef HC595_READBACK_EN
   logic [7:0]  rdata0;
   logic        rdv0;
   logic [15:0] rdata1;
   logic        rdv1;
`endif

   always #5 clk = ~clk;

   hc595_driver #(.N_CHIPS(1), .CLK_DIV(2)) u0 (
      .clk(clk), .rst(rst), .data_in(data0), .valid(valid0),
      .ready(ready0), .done(done0), .oe_en(oe_en),
`ifdef HC595_READBACK_EN
      .hc_q7s(sr0[7]), .rdata(rdata0), .rdata_valid(rdv0),
`endif
      .hc_ds(ds0), .hc_sh_cp(sh0), .hc_st_cp(st0), .hc_mr_n(mr0), .hc_oe_n(oe0)
   );

   hc595_driver #(.N_CHIPS(2), .CLK_DIV(1)) u1 (
      .clk(clk), .rst(rst), .data_in(data1), .valid(valid1),
      .ready(ready1), .done(done1), .oe_en(oe_en),
`ifdef HC595_READBACK_EN
      .hc_q7s(sr1[15]), .rdata(rdata1), .rdata_valid(rdv1),
`endif
      .hc_ds(ds1), .hc_sh_cp(sh1), .hc_st_cp(st1), .hc_mr_n(mr1), .hc_oe_n(oe1)
   );

   always @(posedge sh0 or negedge mr0)
      if (!mr0) sr0 <= '0;
      else      sr0 <= {sr0[6:0], ds0};
   always @(posedge sh0) begin
      rise0  <= rise0 + 1;
      dslog0 <= {dslog0[6:0], ds0};
   end
   always @(posedge st0) begin
      q0          <= sr0;
      stc0        <= stc0 + 1;
      rise_at_st0 <= rise0;
   end

   always @(posedge sh1 or negedge mr1)
      if (!mr1) sr1 <= '0;
      else      sr1 <= {sr1[14:0], ds1};
   always @(posedge sh1) rise1 <= rise1 + 1;
   always @(posedge st1) begin
      q1   <= sr1;
      stc1 <= stc1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One word into u0; returns the cycle index of done (handshake cycle = 0).
   task automatic send0(input logic [7:0] d, input bit busy_poke, output int lat);
      @(negedge clk);
      chk("ready_before_send", 32'(ready0), 32'd1);
      data0  = d;
      valid0 = 1'b1;
      @(posedge clk);
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         lat++;
         valid0 = 1'b0;
         if (busy_poke && lat == 5) begin
            valid0 = 1'b1;
            data0  = 8'hFF;
         end
         if (done0) break;
      end
   endtask

   initial begin
      int lat, r0, s0;
      rst = 1'b1; oe_en = 1'b0;
      data0 = '0; valid0 = 1'b0; data1 = '0; valid1 = 1'b0;

      // reset state
      #12;
      chk("rst_ready",  32'(ready0), 32'd1);
      chk("rst_done",   32'(done0),  32'd0);
      chk("rst_ds",     32'(ds0),    32'd0);
      chk("rst_sh",     32'(sh0),    32'd0);
      chk("rst_st",     32'(st0),    32'd0);
      chk("rst_mr_n",   32'(mr0),    32'd0);
      chk("rst_oe_n",   32'(oe0),    32'd1);
      @(negedge clk); rst = 1'b0;
      #1 chk("mr_n_before_edge", 32'(mr0), 32'd0);
      @(negedge clk);
      chk("mr_n_after_edge", 32'(mr0), 32'd1);
      chk("oe_n_idle", 32'(oe0), 32'd1);

      // single word 0xA5
      r0 = rise0; s0 = stc0;
      send0(8'hA5, 1'b0, lat);
      chk("a5_done_cycle", 32'(lat), 32'd35);
      chk("a5_ds_at_rises", 32'(dslog0), 32'hA5);
      chk("a5_rises", 32'(rise0 - r0), 32'd8);
      chk("a5_st_pulses", 32'(stc0 - s0), 32'd1);
      chk("a5_st_after_8th", 32'(rise_at_st0 - r0), 32'd8);
      chk("a5_q", 32'(q0), 32'hA5);
      chk("a5_ready_in_done", 32'(ready0), 32'd1);
      @(negedge clk);
      chk("a5_done_one_cycle", 32'(done0), 32'd0);

      // back-to-back 0x0F then 0xF0 with valid held high
      r0 = rise0; s0 = stc0;
      data0 = 8'h0F; valid0 = 1'b1;
      @(posedge clk);
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); lat++;
         if (done0) break;
      end
      chk("b2b_first_done", 32'(lat), 32'd35);
      chk("b2b_q_first", 32'(q0), 32'h0F);
      chk("b2b_ready_in_done", 32'(ready0), 32'd1);
      data0 = 8'hF0;
      @(posedge clk);
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); lat++;
         valid0 = 1'b0;
         if (lat == 1) chk("b2b_second_accepted", 32'(ready0), 32'd0);
         if (done0) break;
      end
      chk("b2b_period", 32'(lat), 32'd35);
      chk("b2b_rises", 32'(rise0 - r0), 32'd16);
      chk("b2b_st_pulses", 32'(stc0 - s0), 32'd2);
      chk("b2b_q_final", 32'(q0), 32'hF0);

      // valid pulse while busy is dropped
      r0 = rise0; s0 = stc0;
      send0(8'h5A, 1'b1, lat);
      chk("busy_done_cycle", 32'(lat), 32'd35);
      chk("busy_q", 32'(q0), 32'h5A);
      repeat (40) @(negedge clk);
      chk("busy_rises", 32'(rise0 - r0), 32'd8);
      chk("busy_st_pulses", 32'(stc0 - s0), 32'd1);
      chk("busy_ready_idle", 32'(ready0), 32'd1);
      chk("busy_q_after", 32'(q0), 32'h5A);

      // two-chip chain, CLK_DIV=1
      @(negedge clk);
      data1 = 16'h1234; valid1 = 1'b1;
      @(posedge clk);
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); lat++;
         valid1 = 1'b0;
         if (done1) break;
      end
      chk("chain_done_cycle", 32'(lat), 32'd34);
      chk("chain_rises", 32'(rise1), 32'd16);
      chk("chain_st_pulses", 32'(stc1), 32'd1);
      chk("chain_chip0_q", 32'(q1[7:0]), 32'h34);
      chk("chain_chip1_q", 32'(q1[15:8]), 32'h12);

      // output enable follows ~oe_en one cycle later
      @(negedge clk);
      oe_en = 1'b1;
      #1 chk("oe_no_comb_path", 32'(oe0), 32'd1);
      @(negedge clk);
      chk("oe_on", 32'(oe0), 32'd0);
      oe_en = 1'b0;
      @(negedge clk);
      chk("oe_off", 32'(oe0), 32'd1);

      // reset after the 3rd shift edge
      r0 = rise0; s0 = stc0;
      @(negedge clk);
      data0 = 8'hC7; valid0 = 1'b1;
      @(negedge clk);
      valid0 = 1'b0;
      for (int i = 0; i < 200 && rise0 - r0 < 3; i++) @(negedge clk);
      chk("mid_reached_3_rises", 32'(rise0 - r0), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("mid_ds", 32'(ds0), 32'd0);
      chk("mid_sh", 32'(sh0), 32'd0);
      chk("mid_st", 32'(st0), 32'd0);
      chk("mid_mr_n", 32'(mr0), 32'd0);
      chk("mid_oe_n", 32'(oe0), 32'd1);
      chk("mid_ready", 32'(ready0), 32'd1);
      chk("mid_done", 32'(done0), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("mid_mr_n_held", 32'(mr0), 32'd0);
      @(negedge clk);
      chk("mid_mr_n_release", 32'(mr0), 32'd1);
      repeat (60) begin
         @(negedge clk);
         if (done0) chk("mid_no_done", 32'(done0), 32'd0);
      end
      chk("mid_no_st", 32'(stc0 - s0), 32'd0);
      chk("mid_q_kept", 32'(q0), 32'h5A);
      chk("mid_ready_after", 32'(ready0), 32'd1);

`ifdef HC595_READBACK_EN
      send0(8'h3C, 1'b0, lat);
      send0(8'hC3, 1'b0, lat);
      chk("rb_done", 32'(done0), 32'd1);
      chk("rb_valid_with_done", 32'(rdv0), 32'd1);
      chk("rb_rdata", 32'(rdata0), 32'h3C);
      chk("rb_q", 32'(q0), 32'hC3);
      @(negedge clk);
      chk("rb_valid_pulse", 32'(rdv0), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
